// File: rtl/pc_sequencer.sv
// Program-counter sequencer with prioritised next-PC selection and target alignment.
// Optional return-address stack is present when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer #(
    parameter int                  WIDTH_PC     = 32,
    parameter logic [WIDTH_PC-1:0] RESET_VECTOR = '0,
    parameter int                  PC_INC       = 4,
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_stall,
    input  logic                         i_redirect,
    input  logic [WIDTH_PC-1:0]          i_redirect_pc,
    input  logic                         i_jump,
    input  logic [WIDTH_PC-1:0]          i_jump_pc,
    input  logic                         i_branch_taken,
    input  logic [WIDTH_PC-1:0]          i_branch_pc,
    input  logic                         i_call,
    input  logic                         i_ret,
    output logic [WIDTH_PC-1:0]          o_pc,
    output logic [WIDTH_PC-1:0]          o_pc_plus,
    output logic                         o_misalign,
    output logic                         o_ras_underflow,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count
);

    localparam int                  CNT_W      = $clog2(RAS_DEPTH) + 1;
    localparam logic [WIDTH_PC-1:0] INC        = WIDTH_PC'(PC_INC);
    localparam logic [WIDTH_PC-1:0] ALIGN_MASK = WIDTH_PC'(PC_INC - 1);

    logic [WIDTH_PC-1:0] pc_q, pc_d;
    logic                misalign_q, misalign_d;
    logic [WIDTH_PC-1:0] target;
    logic                load_target;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int SP_W = $clog2(RAS_DEPTH);

    logic [WIDTH_PC-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH_PC-1:0] ras_d [RAS_DEPTH];
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [SP_W-1:0]     sp_top;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                underflow_q, underflow_d;
    logic                push, pop;

    assign sp_top = sp_q - 1'b1;
`else
    logic unused_ras;
    assign unused_ras = i_call ^ i_ret;
`endif

    assign o_pc_plus = pc_q + INC;

    // Redirect outranks everything, so a redirect cycle never touches the stack.
    always_comb begin
        target      = '0;
        load_target = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
        push        = 1'b0;
        pop         = 1'b0;
        underflow_d = 1'b0;
`endif
        if (i_redirect) begin
            target      = i_redirect_pc;
            load_target = 1'b1;
        end
`ifdef PC_SEQUENCER_RAS_EN
        else if (i_ret) begin
            load_target = 1'b1;
            if (count_q != '0) begin
                target = ras_q[sp_top];
                pop    = 1'b1;
            end else begin
                target      = o_pc_plus;
                underflow_d = 1'b1;
            end
        end
`endif
        else if (i_jump) begin
            target      = i_jump_pc;
            load_target = 1'b1;
`ifdef PC_SEQUENCER_RAS_EN
            push        = i_call;
`endif
        end else if (i_branch_taken) begin
            target      = i_branch_pc;
            load_target = 1'b1;
        end

        if (load_target) begin
            pc_d = target & ~ALIGN_MASK;
        end else if (i_stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = o_pc_plus;
        end
        misalign_d = load_target && ((target & ALIGN_MASK) != '0);
    end

`ifdef PC_SEQUENCER_RAS_EN
    // Circular stack: a push when full overwrites the oldest entry and count saturates.
    always_comb begin
        ras_d   = ras_q;
        sp_d    = sp_q;
        count_d = count_q;
        if (push) begin
            ras_d[sp_q] = o_pc_plus;
            sp_d        = sp_q + 1'b1;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            sp_d    = sp_top;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        ras_q <= ras_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sp_q        <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_ras_count     = count_q;
    assign o_ras_underflow = underflow_q;
`else
    assign o_ras_count     = '0;
    assign o_ras_underflow = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; RAS expectations follow PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, jump, branch_taken, call, ret;
    logic [31:0] redirect_pc, jump_pc, branch_pc;
    logic [31:0] pc, pc_plus;
    logic        misalign, ras_underflow;
    logic [2:0]  ras_count;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc),
        .i_jump         (jump),
        .i_jump_pc      (jump_pc),
        .i_branch_taken (branch_taken),
        .i_branch_pc    (branch_pc),
        .i_call         (call),
        .i_ret          (ret),
        .o_pc           (pc),
        .o_pc_plus      (pc_plus),
        .o_misalign     (misalign),
        .o_ras_underflow(ras_underflow),
        .o_ras_count    (ras_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect = 0; jump = 0; branch_taken = 0; call = 0; ret = 0;
    endtask

    task automatic call_jump(input logic [31:0] tgt);
        idle();
        jump = 1; call = 1; jump_pc = tgt;
        step();
        idle();
    endtask

    task automatic do_ret();
        idle();
        ret = 1;
        step();
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        redirect_pc = '0; jump_pc = '0; branch_pc = '0;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus", pc_plus, 32'h4);
        check("rst_misalign", misalign, 0);
        check("rst_underflow", ras_underflow, 0);
        check("rst_count", ras_count, 0);
        #9 rst = 0;   // released between edges
        step(); check("seq_1", pc, 32'h4);
        step(); check("seq_2", pc, 32'h8);
        step(); check("seq_3", pc, 32'hC);

        // stall two cycles, branch on the second
        jump = 1; jump_pc = 32'h100;
        step(); idle();
        check("jump_100", pc, 32'h100);
        check("jump_100_mis", misalign, 0);
        stall = 1;
        step(); check("stall_hold", pc, 32'h100);
        branch_taken = 1; branch_pc = 32'h200;
        step(); idle();
        check("stall_branch", pc, 32'h200);

        // redirect beats jump+call, stack untouched
        redirect = 1; redirect_pc = 32'h80; jump = 1; jump_pc = 32'h400; call = 1;
        step(); idle();
        check("redirect_pc", pc, 32'h80);
        check("redirect_count", ras_count, 0);

        // jump priority over branch
        jump = 1; jump_pc = 32'h300; branch_taken = 1; branch_pc = 32'h500;
        step(); idle();
        check("jump_over_branch", pc, 32'h300);

        // misaligned jump target
        jump = 1; jump_pc = 32'h203;
        step(); idle();
        check("misalign_pc", pc, 32'h200);
        check("misalign_pulse", misalign, 1);
        step();
        check("misalign_clear", misalign, 0);
        check("misalign_seq", pc, 32'h204);

        // return-address stack
        jump = 1; jump_pc = 32'h10;
        step(); idle();
        check("ras_start", pc, 32'h10);
        call_jump(32'h20); call_jump(32'h30); call_jump(32'h40); call_jump(32'h50);
        check("ras_pc_50", pc, 32'h50);
        call_jump(32'h60);
        check("ras_pc_60", pc, 32'h60);
`ifdef PC_SEQUENCER_RAS_EN
        check("ras_full", ras_count, 4);
        do_ret(); check("ret1", pc, 32'h54); check("ret1_cnt", ras_count, 3);
        do_ret(); check("ret2", pc, 32'h44);
        do_ret(); check("ret3", pc, 32'h34);
        do_ret(); check("ret4", pc, 32'h24); check("ret4_cnt", ras_count, 0);
        check("ret4_uf", ras_underflow, 0);
        do_ret();
        check("ret5_pc", pc, 32'h28);
        check("ret5_uf", ras_underflow, 1);
        check("ret5_cnt", ras_count, 0);
        step();
        check("uf_clear", ras_underflow, 0);
        check("uf_seq", pc, 32'h2C);

        // redirect blocks pop
        call_jump(32'h700);
        check("push_one", ras_count, 1);
        redirect = 1; redirect_pc = 32'h900; ret = 1;
        step(); idle();
        check("redir_ret_pc", pc, 32'h900);
        check("redir_ret_cnt", ras_count, 1);

        // ret with call+jump: pop wins, no push
        ret = 1; call = 1; jump = 1; jump_pc = 32'hA00;
        step(); idle();
        check("ret_call_pc", pc, 32'h2C + 32'h4);
        check("ret_call_cnt", ras_count, 0);
`else
        check("noras_count", ras_count, 0);
        do_ret();
        check("noras_ret_pc", pc, 32'h64);
        check("noras_ret_uf", ras_underflow, 0);
        ret = 1; stall = 1;
        step(); idle();
        check("noras_ret_stall", pc, 32'h64);
`endif

        // wrap at the top of the address space
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        step(); idle();
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        check("wrap_plus", pc_plus, 32'h0);
        step();
        check("wrap", pc, 32'h0);
        step();
        check("wrap_next", pc, 32'h4);

        // async reset mid-cycle with pending redirect and stall
        redirect = 1; redirect_pc = 32'h800; stall = 1;
        #2 rst = 1;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_cnt", ras_count, 0);
        @(posedge clk); #1;
        check("rst_held_pc", pc, 32'h0);
        idle();
        #2 rst = 0;
        step();
        check("post_rst_1", pc, 32'h4);
        check("post_rst_mis", misalign, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH_PC, 32, PC register width (16..64).
REQ-002 Parameter RESET_VECTOR, 0, PC value loaded on reset.
REQ-003 Parameter PC_INC, 4, sequential increment, power of two.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries (2..16, power of two).
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_stall  in  1  hold PC.
REQ-008 i_redirect  in  1  exception/trap redirect request.
REQ-009 i_redirect_pc  in  WIDTH_PC  redirect target.
REQ-010 i_jump  in  1  unconditional jump.
REQ-011 i_jump_pc  in  WIDTH_PC  jump target.
REQ-012 i_branch_taken  in  1  resolved taken branch.
REQ-013 i_branch_pc  in  WIDTH_PC  branch target.
REQ-014 i_call  in  1  push return address (qualifies i_jump).
REQ-015 i_ret  in  1  pop return address as next PC.
REQ-016 o_pc  out  WIDTH_PC  current PC (registered).
REQ-017 o_pc_plus  out  WIDTH_PC  o_pc + PC_INC, combinational.
REQ-018 o_misalign  out  1  one-cycle pulse: accepted target had nonzero low bits.
REQ-019 o_ras_underflow  out  1  one-cycle pulse: i_ret with empty stack.
REQ-020 o_ras_count  out  clog2(RAS_DEPTH)+1  occupied RAS entries.

Function
REQ-021 Next-PC priority, highest first: i_redirect, i_ret, i_jump, i_branch_taken, i_stall, sequential.
REQ-022 i_redirect, i_jump, i_branch_taken SHALL take effect even when i_stall is high; i_ret likewise.
REQ-023 Selected target SHALL be loaded into o_pc on the next rising edge (latency 1).
REQ-024 Sequential update SHALL be o_pc <= o_pc + PC_INC, wrapping modulo 2^WIDTH_PC.
REQ-025 With i_stall high and no higher-priority request, o_pc SHALL hold.
REQ-026 Loaded targets SHALL have low log2(PC_INC) bits forced to zero; o_misalign SHALL pulse the cycle after when any forced bit was 1.
REQ-027 i_call with i_jump accepted SHALL push o_pc_plus; i_call without i_jump SHALL be ignored.
REQ-028 Push when full SHALL overwrite the oldest entry (circular); o_ras_count stays RAS_DEPTH.
REQ-029 i_ret with count > 0 SHALL load the top entry and decrement count.
REQ-030 i_ret with count 0 SHALL load o_pc_plus, leave count 0, pulse o_ras_underflow.
REQ-031 i_redirect SHALL block any simultaneous push or pop (stack unchanged).
REQ-032 Simultaneous i_ret and i_call: pop wins, no push.
REQ-033 All outputs except o_pc_plus SHALL be registered.

Reset
REQ-034 i_rst high SHALL immediately set o_pc=RESET_VECTOR, o_ras_count=0, o_misalign=0, o_ras_underflow=0, independent of i_clk.
REQ-035 RAS entry contents need not be cleared.
REQ-036 First update after deassertion SHALL occur on the first rising edge with i_rst low.
REQ-037 Reset mid-stall or mid-redirect SHALL discard the pending request.

Configuration
REQ-038 Macro PC_SEQUENCER_RAS_EN defined: RAS logic present per REQ-027..REQ-032.
REQ-039 Macro undefined: no RAS storage; i_call and i_ret ignored; o_ras_count and o_ras_underflow tied 0; i_ret does not affect next PC.

Verification
REQ-040 Reset release, no requests, 3 clocks -> o_pc 0x0, 0x4, 0x8, 0xC.
REQ-041 o_pc=0x100, i_stall=1 for 2 cycles with i_branch_taken=1, i_branch_pc=0x200 on 2nd -> o_pc 0x100 then 0x200.
REQ-042 Same cycle i_redirect=1 (0x80), i_jump=1 (0x400), i_call=1 -> o_pc=0x80, o_ras_count unchanged.
REQ-043 RAS_EN, RAS_DEPTH=4: five call/jumps from PCs 0x10,0x20,0x30,0x40,0x50, then five i_ret -> returns 0x54,0x44,0x34,0x24, fifth ret gives o_pc_plus with o_ras_underflow pulse.
REQ-044 i_jump_pc=0x203 -> o_pc=0x200, o_misalign high exactly one cycle.
REQ-045 o_pc=0xFFFFFFFC, sequential step -> o_pc=0x0; i_rst asserted mid-cycle -> o_pc=RESET_VECTOR before next edge.
